seg7_display: RTL and testbench
===============================

SEG7_DISPLAY -- requirements
Module: seg7_display

Interface
REQ-001 The parameter CLK_DIV SHALL default to 50000 and set the number of clk cycles each digit is lit.
REQ-002 The parameter LZ_BLANK SHALL default to 0; when 1, leading-zero blanking is enabled.
REQ-003 clk  input  1  system clock; the block has one clock, and all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 disp_data  input  32  eight hex nibbles to display; nibble i is disp_data[4i+3:4i].
REQ-006 disp_load  input  1  capture strobe; disp_data is sampled on any rising edge where disp_load=1.
REQ-007 an  output  8  digit enables, active-low, one-hot-low; an[i] selects nibble i.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  output  1  decimal point, active-low; held at 1 (off) at all times.

Function
REQ-010 A 32-bit hold register SHALL load disp_data on each rising edge with disp_load=1 and SHALL otherwise keep its value.
REQ-011 The prescaler SHALL be ceil(log2(CLK_DIV)) bits wide, count 0..CLK_DIV-1 and wrap to 0.
- Tick = prescaler at CLK_DIV-1.
REQ-012 The 3-bit digit index SHALL increment on each tick and wrap from 7 to 0.
REQ-013 an and seg SHALL be registered and SHALL reflect, one cycle late, the index and hold register of the previous cycle.
- an = ~(1<<idx).
- seg = decode(hold nibble idx).
REQ-014 The decode table in hex SHALL be:
- 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
- 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
REQ-015 With LZ_BLANK=1, digit i (i>0) SHALL be blanked (seg=7F, an still driven) when nibbles 7..i of the hold register are all zero.
- Digit 0 is never blanked.
REQ-016 When load and tick coincide, both SHALL take effect, and the newly selected digit SHALL show the new data one cycle later.
REQ-017 A load of data equal to the current hold value SHALL cause no visible change; the scan phase SHALL be unaffected by loads.
REQ-018 With CLK_DIV=1, the index SHALL advance every cycle.
REQ-019 A CLK_DIV of 0 SHALL be treated as 1.

Reset
REQ-020 While rst=0, the block SHALL hold the following values, applied asynchronously:
- an=FF, seg=7F, dp=1
- hold register=0, prescaler=0, index=0
REQ-021 On the first rising edge after rst deasserts, the block SHALL drive an=FE and seg=decode(0)=40 (the hold register is zero).
REQ-022 An assertion of rst in mid-scan SHALL abort the scan immediately without waiting for a clock edge.
REQ-023 A disp_load coincident with rst=0 SHALL be ignored.

Structure
REQ-024 The shared package SHALL hold the digit count (8), the segment code constants for 0-F and blank (7F), and the all-off enable constant (FF).
REQ-025 The hex-to-segment decoder SHALL be a combinational sub-module named seg7_decode, with a 4-bit input and 7-bit output.
REQ-026 seg7_display SHALL instantiate exactly one seg7_decode, fed by the muxed nibble; all other logic (prescaler, index, hold, blanking, output registers) SHALL reside in seg7_display.

Verification
REQ-027 Reset check, with CLK_DIV=4 -> an=FF, seg=7F and dp=1 during reset; an=FE and seg=40 on the first edge after release.
REQ-028 Scan check: CLK_DIV=4, load 12345678 -> an steps through FE, FD, ..., 7F, changing every 4 cycles with seg=00, 78, 02, 12, 19, 30, 24, 79, then wraps to FE.
REQ-029 Leading-zero check: LZ_BLANK=1, load 000000A0 -> digits 7..2 show seg=7F, digit 1 shows 08, digit 0 shows 40; load 00000000 -> only digit 0 shows 40.
REQ-030 Collision check: load DEADBEEF on the tick cycle into idx=3 -> the cycle after, an=F7 and seg=03 (nibble 3 = b).
REQ-031 Mid-scan reset: assert rst at idx=5 between edges -> an=FF and seg=7F immediately; after release, the scan restarts at an=FE and hold=0.
REQ-032 CLK_DIV=1 -> an rotates to a new digit every cycle; the index wraps from 7 to 0 after 8 cycles.

Source files
------------

// File: rtl/seg7_display_pkg.sv
// Shared constants for the eight-digit seven-segment scanner: digit count,
// active-low segment codes {g,f,e,d,c,b,a} and the all-off enable pattern.
package seg7_display_pkg;

  localparam int NumDigits = 8;

  localparam logic [6:0] Seg0 = 7'h40;
  localparam logic [6:0] Seg1 = 7'h79;
  localparam logic [6:0] Seg2 = 7'h24;
  localparam logic [6:0] Seg3 = 7'h30;
  localparam logic [6:0] Seg4 = 7'h19;
  localparam logic [6:0] Seg5 = 7'h12;
  localparam logic [6:0] Seg6 = 7'h02;
  localparam logic [6:0] Seg7 = 7'h78;
  localparam logic [6:0] Seg8 = 7'h00;
  localparam logic [6:0] Seg9 = 7'h10;
  localparam logic [6:0] SegA = 7'h08;
  localparam logic [6:0] SegB = 7'h03;
  localparam logic [6:0] SegC = 7'h46;
  localparam logic [6:0] SegD = 7'h21;
  localparam logic [6:0] SegE = 7'h06;
  localparam logic [6:0] SegF = 7'h0E;
  localparam logic [6:0] SegBlank = 7'h7F;

  localparam logic [7:0] AnOff = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment code.
module seg7_decode
  import seg7_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegBlank;
    unique case (hex)
      4'h0: seg = Seg0;
      4'h1: seg = Seg1;
      4'h2: seg = Seg2;
      4'h3: seg = Seg3;
      4'h4: seg = Seg4;
      4'h5: seg = Seg5;
      4'h6: seg = Seg6;
      4'h7: seg = Seg7;
      4'h8: seg = Seg8;
      4'h9: seg = Seg9;
      4'hA: seg = SegA;
      4'hB: seg = SegB;
      4'hC: seg = SegC;
      4'hD: seg = SegD;
      4'hE: seg = SegE;
      4'hF: seg = SegF;
    endcase
  end

endmodule

// File: rtl/seg7_display.sv
// Eight-digit multiplexed seven-segment driver: holds a 32-bit value and scans
// one digit every CLK_DIV clocks, with optional leading-zero blanking.
module seg7_display
  import seg7_display_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50000,
  parameter bit          LZ_BLANK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data,
  input  logic        disp_load,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // A divide of zero behaves as divide-by-one.
  localparam int unsigned Div = (CLK_DIV == 0) ? 1 : CLK_DIV;
  localparam int unsigned PsW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(Div - 1);

  logic [PsW-1:0]       ps_q, ps_d;
  logic [2:0]           idx_q, idx_d;
  logic [31:0]          hold_q, hold_d;
  logic [7:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 tick;
  logic [3:0]           nibble;
  logic [6:0]           dec_seg;
  logic [NumDigits-1:0] nz_upper;
  logic                 nz_acc;
  logic                 blank;

  always_comb begin
    tick   = (ps_q == PsMax);
    ps_d   = tick ? '0 : ps_q + 1'b1;
    idx_d  = tick ? idx_q + 3'd1 : idx_q;
    hold_d = disp_load ? disp_data : hold_q;
    nibble = hold_q[{idx_q, 2'b00} +: 4];
  end

  // nz_upper[i] is set when any nibble from i up to the top is non-zero.
  always_comb begin
    nz_upper = '0;
    nz_acc   = 1'b0;
    for (int i = NumDigits - 1; i >= 0; i--) begin
      nz_acc      = nz_acc | (|hold_q[4*i +: 4]);
      nz_upper[i] = nz_acc;
    end
  end

  seg7_decode u_decode (
    .hex (nibble),
    .seg (dec_seg)
  );

  always_comb begin
    blank = LZ_BLANK && (idx_q != 3'd0) && !nz_upper[idx_q];
    an_d  = ~(8'b1 << idx_q);
    seg_d = blank ? SegBlank : dec_seg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q   <= '0;
      idx_q  <= '0;
      hold_q <= '0;
      an_q   <= AnOff;
      seg_q  <= SegBlank;
    end else begin
      ps_q   <= ps_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_display.sv
// Bench for seg7_display: four instances (divide 4, divide 4 with blanking,
// divide 1, divide 0) against a cycle-count model plus directed literal checks.
module tb_seg7_display;

  logic        clk;
  logic        rst;
  logic [31:0] disp_data;
  logic        disp_load;

  logic [7:0] an_a, an_b, an_c, an_d;
  logic [6:0] seg_a, seg_b, seg_c, seg_d;
  logic       dp_a, dp_b, dp_c, dp_d;

  int checks = 0;
  int errors = 0;

  seg7_display #(.CLK_DIV(4), .LZ_BLANK(1'b0)) u_a (
    .clk(clk), .rst(rst), .disp_data(disp_data), .disp_load(disp_load),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );
  seg7_display #(.CLK_DIV(4), .LZ_BLANK(1'b1)) u_b (
    .clk(clk), .rst(rst), .disp_data(disp_data), .disp_load(disp_load),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );
  seg7_display #(.CLK_DIV(1), .LZ_BLANK(1'b0)) u_c (
    .clk(clk), .rst(rst), .disp_data(disp_data), .disp_load(disp_load),
    .an(an_c), .seg(seg_c), .dp(dp_c)
  );
  seg7_display #(.CLK_DIV(0), .LZ_BLANK(1'b0)) u_d (
    .clk(clk), .rst(rst), .disp_data(disp_data), .disp_load(disp_load),
    .an(an_d), .seg(seg_d), .dp(dp_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: k counts edges since reset release; hold_prev is the held value
  // as it stood before the most recent edge, which is what the outputs show.
  int          k;
  logic [31:0] hold_m, hold_prev;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k         <= 0;
      hold_m    <= '0;
      hold_prev <= '0;
    end else begin
      k         <= k + 1;
      hold_prev <= hold_m;
      if (disp_load) hold_m <= disp_data;
    end
  end

  function automatic logic [14:0] model(int div, bit lz, int kk, logic [31:0] h, bit in_rst);
    int d, idx;
    int unsigned upper;
    bit blank;
    if (in_rst || kk == 0) return {8'hFF, 7'h7F};
    d     = (div < 1) ? 1 : div;
    idx   = ((kk - 1) / d) % 8;
    upper = h / (32'd1 << (4 * idx));
    blank = lz && (idx > 0) && (upper == 0);
    return {~(8'd1 << idx), blank ? 7'h7F : seg_tab[upper % 16]};
  endfunction

  task automatic chk(string name, logic [7:0] an_g, logic [6:0] seg_g, logic dp_g,
                     logic [14:0] exp_v);
    checks++;
    if (an_g !== exp_v[14:7] || seg_g !== exp_v[6:0] || dp_g !== 1'b1) begin
      errors++;
      $display("FAIL %s k=%0d t=%0t: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=1",
               name, k, $time, an_g, seg_g, dp_g, exp_v[14:7], exp_v[6:0]);
    end
  endtask

  always @(negedge clk) begin
    chk("model_div4", an_a, seg_a, dp_a, model(4, 1'b0, k, hold_prev, !rst));
    chk("model_div4_lz", an_b, seg_b, dp_b, model(4, 1'b1, k, hold_prev, !rst));
    chk("model_div1", an_c, seg_c, dp_c, model(1, 1'b0, k, hold_prev, !rst));
    chk("model_div0", an_d, seg_d, dp_d, model(0, 1'b0, k, hold_prev, !rst));
  end

  task automatic lit(string name, int sel, logic [7:0] an_e, logic [6:0] seg_e);
    logic [7:0] a;
    logic [6:0] s;
    logic       d;
    case (sel)
      0:       begin a = an_a; s = seg_a; d = dp_a; end
      1:       begin a = an_b; s = seg_b; d = dp_b; end
      2:       begin a = an_c; s = seg_c; d = dp_c; end
      default: begin a = an_d; s = seg_d; d = dp_d; end
    endcase
    checks++;
    if (a !== an_e || s !== seg_e || d !== 1'b1) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=1",
               name, a, s, d, an_e, seg_e);
    end
  endtask

  // Returns at the falling edge where the model's edge count reaches target.
  task automatic wait_k(int target);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (k != target && g < 2000);
    if (k != target) begin
      errors++;
      $display("FAIL wait_k: edge count %0d, required %0d", k, target);
    end
  endtask

  logic [6:0] scan_seg [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [7:0] scan_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  initial begin
    rst       = 1'b1;
    disp_load = 1'b1;
    disp_data = 32'h1234_5678;
    #1 rst = 1'b0;

    // Reset values, with a load pending that must be ignored while in reset.
    repeat (2) @(negedge clk);
    lit("reset_div4", 0, 8'hFF, 7'h7F);
    lit("reset_div1", 2, 8'hFF, 7'h7F);
    @(posedge clk);
    #2 rst = 1'b1;

    // First edge shows digit 0 of a still-zero hold register; it also loads.
    wait_k(1);
    lit("first_edge", 0, 8'hFE, 7'h40);
    disp_load = 1'b0;

    for (int d = 0; d < 8; d++) begin
      wait_k(4 * d + 4);
      lit("scan_12345678", 0, scan_an[d], scan_seg[d]);
      lit("scan_12345678_lz", 1, scan_an[d], scan_seg[d]);
    end
    wait_k(36);
    lit("scan_wrap", 0, 8'hFE, 7'h00);

    disp_load = 1'b1;
    disp_data = 32'h0000_00A0;
    wait_k(37);
    disp_load = 1'b0;
    for (int d = 0; d < 8; d++) begin
      wait_k(68 + 4 * d);
      lit("lz_000000A0", 1, scan_an[d], (d == 0) ? 7'h40 : (d == 1) ? 7'h08 : 7'h7F);
      lit("nolz_000000A0", 0, scan_an[d], (d == 1) ? 7'h08 : 7'h40);
    end

    disp_load = 1'b1;
    disp_data = 32'h0000_0000;
    wait_k(97);
    disp_load = 1'b0;
    for (int d = 0; d < 8; d++) begin
      wait_k(100 + 4 * d);
      lit("lz_zero", 1, scan_an[d], (d == 0) ? 7'h40 : 7'h7F);
    end

    // Load sampled on the same edge that moves the index from 2 to 3.
    wait_k(139);
    disp_load = 1'b1;
    disp_data = 32'hDEAD_BEEF;
    wait_k(140);
    disp_load = 1'b0;
    lit("collision_before", 0, 8'hFB, 7'h40);
    wait_k(141);
    lit("collision_after", 0, 8'hF7, 7'h03);

    // Mid-scan reset while digit 5 (nibble A) is lit.
    wait_k(182);
    lit("pre_reset_idx5", 0, 8'hDF, 7'h08);
    #2 rst = 1'b0;
    #1;
    lit("midscan_reset_div4", 0, 8'hFF, 7'h7F);
    lit("midscan_reset_lz", 1, 8'hFF, 7'h7F);
    lit("midscan_reset_div1", 2, 8'hFF, 7'h7F);
    lit("midscan_reset_div0", 3, 8'hFF, 7'h7F);
    @(posedge clk);
    #2 rst = 1'b1;

    wait_k(1);
    lit("restart_div4", 0, 8'hFE, 7'h40);
    lit("restart_div1", 2, 8'hFE, 7'h40);
    lit("restart_div0", 3, 8'hFE, 7'h40);
    wait_k(2);
    lit("restart_hold_zero", 0, 8'hFE, 7'h40);
    lit("div1_step", 2, 8'hFD, 7'h40);
    lit("div0_step", 3, 8'hFD, 7'h40);
    wait_k(8);
    lit("div1_digit7", 2, 8'h7F, 7'h40);
    wait_k(9);
    lit("div1_wrap", 2, 8'hFE, 7'h40);
    lit("div0_wrap", 3, 8'hFE, 7'h40);
    wait_k(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
